reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file with an integrated write-pending scoreboard, for the dual-issue TURTLE core.
- N read ports and M write ports, with same-cycle write-to-read bypass and a hard-wired zero register.
- Per-register busy bits are set at issue and cleared at writeback, so decode can detect RAW hazards without a separate scoreboard block.

---
 rtl/reg_file_mp.sv | 96 +++++++++
 tb/tb_reg_file_mp.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass, hard-wired x0
// and a per-register write-pending scoreboard for RAW hazard detection.
module reg_file_mp #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter int              NUM_RD   = 2,
  parameter int              NUM_WR   = 1,
  parameter int              SP_INDEX = 2,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'(32'h80000800),
  localparam int             AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   sb_set_en,
  input  logic [AW-1:0]          sb_set_addr,
  output logic [AW:0]            busy_count
);

  logic [XLEN-1:0]    regs [1:NREGS-1];
  logic [NREGS-1:1]   busy;

  logic [NREGS-1:1]   wr_hit;
  logic [XLEN-1:0]    wr_val [1:NREGS-1];
  logic [NREGS-1:1]   busy_next;
  logic [AW:0]        busy_next_count;
  logic [XLEN-1:0]    view [NREGS];
  logic [NREGS-1:0]   busy_view;

  // Ascending port scan so the highest-numbered enabled port wins a collision.
  always_comb begin
    wr_hit = '0;
    for (int r = 1; r < NREGS; r++) begin
      wr_val[r] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // A new issue to the same register outranks the retiring producer's clear.
  always_comb begin
    busy_next       = '0;
    busy_next_count = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy_next[r] = (busy[r] & ~wr_hit[r]) |
                     (sb_set_en && (sb_set_addr == AW'(r)));
      busy_next_count = busy_next_count + (AW+1)'(busy_next[r]);
    end
  end

  always_comb begin
    view[0]      = '0;
    busy_view[0] = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      view[r]      = wr_hit[r] ? wr_val[r] : regs[r];
      busy_view[r] = busy[r] & ~wr_hit[r];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p*XLEN +: XLEN] = view[rd_addr[p*AW +: AW]];
      rd_busy[p]              = busy_view[rd_addr[p*AW +: AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < NREGS; r++) begin
        regs[r] <= (r == SP_INDEX) ? SP_RESET : '0;
      end
      busy       <= '0;
      busy_count <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
      busy       <= busy_next;
      busy_count <= busy_next_count;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed register-file scenarios plus randomized
// traffic compared every cycle against an array-based reference model.
module tb_reg_file_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;
  localparam logic [31:0] SP_VAL = 32'h80000800;

  logic                   clk;
  logic                   reset;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   sb_set_en;
  logic [AW-1:0]          sb_set_addr;
  logic [AW:0]            busy_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [NREGS];
  bit   [NREGS-1:0] m_busy;
  int   m_count;
  bit   model_valid = 1'b0;

  reg_file_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .SP_INDEX(2), .SP_RESET(SP_VAL)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit written_now(input logic [4:0] a);
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    for (int w = NUM_WR-1; w >= 0; w--)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) return wr_data[w*XLEN +: XLEN];
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a);
    return {31'b0, (a != 0) && m_busy[a] && !written_now(a)};
  endfunction

  // Reference model: architectural state advanced at each clock edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 32'h0;
      m_regs[2]   = SP_VAL;
      m_busy      = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
          m_regs[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
          m_busy[wr_addr[w*AW +: AW]] = 1'b0;
        end
      end
      if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    end
    m_count = $countones(m_busy);
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int p = 0; p < NUM_RD; p++) begin
        check_output($sformatf("model rd_data[%0d] x%0d", p, rd_addr[p*AW +: AW]),
                     rd_data[p*XLEN +: XLEN], exp_data(rd_addr[p*AW +: AW]));
        check_output($sformatf("model rd_busy[%0d] x%0d", p, rd_addr[p*AW +: AW]),
                     {31'b0, rd_busy[p]}, exp_busy(rd_addr[p*AW +: AW]));
      end
      check_output("model busy_count", {26'b0, busy_count}, 32'(m_count));
    end
  end

  task automatic apply_stimulus(input logic rst, input logic [1:0] en,
                                input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic sb_en, input logic [4:0] sb_a,
                                input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk);
    #1;
    reset       = rst;
    wr_en       = en;
    wr_addr     = {wa1, wa0};
    wr_data     = {wd1, wd0};
    sb_set_en   = sb_en;
    sb_set_addr = sb_a;
    rd_addr     = {ra1, ra0};
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    apply_stimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1);
  endtask

  initial begin
    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; rd_addr = '0;

    idle(5'd2, 5'd2);
    check_output("reset x2 port0", rd_data[31:0], 32'h80000800);
    check_output("reset x2 port1", rd_data[63:32], 32'h80000800);
    check_output("reset rd_busy", {30'b0, rd_busy}, 32'h0);
    check_output("reset busy_count", {26'b0, busy_count}, 32'h0);
    idle(5'd1, 5'd5);
    check_output("reset x1", rd_data[31:0], 32'h0);
    check_output("reset x5", rd_data[63:32], 32'h0);
    idle(5'd31, 5'd0);
    check_output("reset x31", rd_data[31:0], 32'h0);

    apply_stimulus(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    check_output("bypass x5", rd_data[31:0], 32'hDEADBEEF);
    idle(5'd5, 5'd0);
    check_output("stored x5", rd_data[31:0], 32'hDEADBEEF);
    apply_stimulus(1'b0, 2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_output("write x0 bypass", rd_data[31:0], 32'h0);

    apply_stimulus(1'b0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
    check_output("collision bypass p0", rd_data[31:0], 32'h22);
    check_output("collision bypass p1", rd_data[63:32], 32'h22);
    idle(5'd7, 5'd0);
    check_output("collision stored", rd_data[31:0], 32'h22);

    apply_stimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    check_output("sb_set same-cycle busy", {31'b0, rd_busy[0]}, 32'h0);
    idle(5'd9, 5'd0);
    check_output("x9 busy", {31'b0, rd_busy[0]}, 32'h1);
    check_output("count after set x9", {26'b0, busy_count}, 32'h1);
    apply_stimulus(1'b0, 2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    check_output("writeback busy", {31'b0, rd_busy[0]}, 32'h0);
    check_output("writeback data", rd_data[31:0], 32'h55);
    idle(5'd9, 5'd0);
    check_output("count after wb", {26'b0, busy_count}, 32'h0);

    apply_stimulus(1'b0, 2'b01, 5'd9, 32'h66, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    check_output("set beats clear busy", {31'b0, rd_busy[0]}, 32'h1);
    check_output("set beats clear count", {26'b0, busy_count}, 32'h1);
    apply_stimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    check_output("x0 busy", {31'b0, rd_busy[0]}, 32'h0);
    idle(5'd0, 5'd0);
    check_output("sb_set x0 count", {26'b0, busy_count}, 32'h1);

    apply_stimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0);
    apply_stimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
    apply_stimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd0, 5'd0);
    apply_stimulus(1'b0, 2'b01, 5'd2, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd0);
    check_output("x2 bypass 99", rd_data[31:0], 32'h99);
    idle(5'd3, 5'd4);
    check_output("x3 x4 busy", {30'b0, rd_busy}, 32'h3);
    check_output("count 3 busy", {26'b0, busy_count}, 32'h3);
    apply_stimulus(1'b1, 2'b01, 5'd3, 32'h77, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd2);
    idle(5'd2, 5'd3);
    check_output("re-reset x2", rd_data[31:0], 32'h80000800);
    check_output("re-reset x3", rd_data[63:32], 32'h0);
    check_output("re-reset count", {26'b0, busy_count}, 32'h0);
    check_output("re-reset busy x2 x3", {30'b0, rd_busy}, 32'h0);
    idle(5'd4, 5'd9);
    check_output("re-reset busy x4 x9", {30'b0, rd_busy}, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      logic [4:0] a [6];
      for (int k = 0; k < 6; k++)
        a[k] = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      apply_stimulus(1'($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)),
                     a[0], $urandom, a[1], $urandom,
                     1'($urandom_range(0, 2) != 0), a[2], a[3], a[4]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
